tpuv1_mmio_ctrl: RTL and testbench
==================================

Name: tpuv1_mmio_ctrl

Overview:
- Responder side of the tpuv1 host bus (addr/dataIn/dataOut/r_w); the host initiator drives it.
- Decodes host accesses into A-row writes, B-row pushes, C half-row reads/writes and a compute start.
- Sequences the systolic-array compute window and muxes C read data back onto dataOut.
- Sits inside tpuv1, between the host bus and the memA/memB/systolic_array datapath.

Parameters:
- BITS_AB, 8, A/B element width.
- BITS_C, 16, C element width.
- DIM, 8, array dimension; address map below is fixed for DIM=8.
- ADDRW, 16, host address width.
- DATAW, 64, host data width; DATAW = DIM*BITS_AB = (DIM*BITS_C)/2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- addr  in  ADDRW  host address.
- r_w  in  1  1 = write, 0 = read.
- dataIn  in  DATAW  host write data.
- dataOut  out  DATAW  host read data.
- busy  out  1  compute window active.
- done  out  1  one-cycle pulse at end of compute.
- a_wr_en  out  1  write one A row.
- a_wr_row  out  $clog2(DIM)  A row index.
- b_wr_en  out  1  push one B row.
- ab_wr_data  out  DATAW  dataIn pass-through for A/B writes.
- c_wr_en  out  1  write one C half-row.
- c_wr_hi  out  1  half select for the C write: 1 = cols DIM/2..DIM-1.
- c_row  out  $clog2(DIM)  C row index, read and write.
- c_rd_data  in  DIM*BITS_C  C row data for c_row, combinational from the array.
- mem_en  out  1  memA/memB skew/shift enable.
- sa_en  out  1  systolic_array enable.

Behaviour:
- Reset: synchronous, active-low on rst_n at posedge clk (already decided). While low, all registered state clears: FSM to IDLE, counter to 0, busy = done = 0. Reset mid-compute aborts the run at the next edge.
- Address map. A: 0x100–0x13F, row = addr[5:3]. B: any write in 0x200–0x23F is a push. C: 0x300–0x37F, row = addr[6:4], half = addr[3]. Start: 0x400.
- Strobes are combinational from addr/r_w: a_wr_en, b_wr_en, c_wr_en, c_row, c_wr_hi.
- All write strobes are gated by ~busy and by rst_n. The datapath samples them at posedge clk, so a write takes effect one cycle after the strobe is presented.
- Host writes during busy (A, B, C or start) are dropped with no side effect.
- Reads: dataOut is combinational, zero-latency.
  - C range: addr[3] = 1 gives c_rd_data[DIM*BITS_C-1 : DATAW]; addr[3] = 0 gives the low DATAW bits.
  - Any other address, or r_w = 1: dataOut = 0.
  - C reads are allowed during busy and return live, partial data.
- c_row always follows addr[6:4] so read data is available the same cycle.
- FSM IDLE:
  - A write to 0x400 moves to RUN.
  - cnt <= 0.
- FSM RUN:
  - busy = mem_en = sa_en = 1.
  - cnt increments each cycle.
  - When cnt == RUN_CYC-1, go to DONE. RUN_CYC = 3*DIM-1 = 23.
- FSM DONE:
  - done = 1 and busy = 0 for one cycle, then IDLE.
  - A start write in DONE is accepted and goes to RUN next cycle.
- Latency: the start write at edge N puts busy high from N+1 through N+23; done is high in cycle N+24. Results are readable from N+24.
- Counter: width $clog2(RUN_CYC)+1, no wrap in RUN; it is cleared on entry to RUN.
- Precedence when events coincide: reset > start > normal writes. A write is never to two regions at once, because the regions are disjoint.

Decomposition:
- Package tpuv1_pkg holds:
  - address bases A_BASE=0x100, B_BASE=0x200, C_BASE=0x300, START_ADDR=0x400;
  - region masks;
  - RUN_CYC;
  - typedef enum logic[1:0] {IDLE, RUN, DONE} ctrl_state_t.
- Sub-module tpuv1_addr_decode holds the combinational region and row decode. The FSM and counter stay in the top.

Test Plan:
- Reset with addr=0x310 held and c_rd_data = all 0x5A -> FSM in IDLE, busy=0, done=0; dataOut=0x5A5A…5A (live read still works); a write to 0x400 held during reset does not start a run.
- Write 0x100+8*r for r=0..7, data 0x0101…*r -> a_wr_en=1 with a_wr_row=r each cycle; ab_wr_data = dataIn. Write to 0x200 three times -> three b_wr_en pulses.
- Read 0x338 with c_rd_data = {64'hAAAA…, 64'h1111…} -> c_row=3, dataOut=0xAAAA… in the same cycle. Read 0x330 -> 0x1111…. Read 0x500 -> 0.
- Write 0x400 at edge N -> busy and sa_en high for exactly 23 cycles; done pulses once at N+24; busy low afterwards.
- Writes to 0x100, 0x200, 0x300 and 0x400 during busy -> no strobes and no restart; run length stays 23.
- Start at N, then rst_n low at N+10 -> busy=0 from N+11; no done pulse; a new start after reset runs the full 23 cycles.

Source files
------------

// File: rtl/tpuv1_pkg.sv
// Shared definitions for the tpuv1 host-side MMIO controller.
// Holds the fixed DIM=8 address map, the compute window length and the
// controller state encoding used by tpuv1_mmio_ctrl and tpuv1_addr_decode.
package tpuv1_pkg;

    // The address map is defined over a 16-bit host address.
    localparam int unsigned MAP_AW = 16;

    localparam logic [MAP_AW-1:0] A_BASE     = 16'h0100;
    localparam logic [MAP_AW-1:0] A_MASK     = 16'hFFC0;  // 0x100..0x13F
    localparam logic [MAP_AW-1:0] B_BASE     = 16'h0200;
    localparam logic [MAP_AW-1:0] B_MASK     = 16'hFFC0;  // 0x200..0x23F
    localparam logic [MAP_AW-1:0] C_BASE     = 16'h0300;
    localparam logic [MAP_AW-1:0] C_MASK     = 16'hFF80;  // 0x300..0x37F
    localparam logic [MAP_AW-1:0] START_ADDR = 16'h0400;

    // Cycles the array needs to fill, compute and drain: 3*DIM-1 for DIM=8.
    localparam int unsigned RUN_CYC = 23;
    localparam int unsigned CNT_W   = $clog2(RUN_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    function automatic logic in_region(input logic [MAP_AW-1:0] a,
                                       input logic [MAP_AW-1:0] base,
                                       input logic [MAP_AW-1:0] mask);
        return (a & mask) == base;
    endfunction

endpackage

// File: rtl/tpuv1_mmio_ctrl_if.sv
// Host bus of tpuv1: the host (master) drives addr/r_w/dataIn and samples
// dataOut; the controller (slave) responds.
//   addr    ADDRW  host address
//   r_w     1      1 = write, 0 = read
//   dataIn  DATAW  host write data
//   dataOut DATAW  host read data (combinational from the responder)
interface tpuv1_mmio_ctrl_if #(
    parameter int unsigned ADDRW = 16,
    parameter int unsigned DATAW = 64
);
    logic [ADDRW-1:0] addr;
    logic             r_w;
    logic [DATAW-1:0] dataIn;
    logic [DATAW-1:0] dataOut;

    modport master (output addr, output r_w, output dataIn, input dataOut);
    modport slave  (input addr, input r_w, input dataIn, output dataOut);
endinterface

// File: rtl/tpuv1_addr_decode.sv
// Combinational decode of a host access into datapath strobes and C read mux.
// Ports:
//   i_addr, i_r_w      host access
//   i_busy, i_rst_n    write gating (writes are dropped while busy or in reset)
//   i_c_rd_data        C row for o_c_row, from the array
//   o_a_wr_en/o_a_wr_row   A row write
//   o_b_wr_en              B row push
//   o_c_wr_en/o_c_wr_hi    C half-row write
//   o_c_row                C row index (always follows addr[6:4])
//   o_start                compute start request
//   o_data_out             host read data
module tpuv1_addr_decode
    import tpuv1_pkg::*;
#(
    parameter int unsigned BITS_C = 16,
    parameter int unsigned DIM    = 8,
    parameter int unsigned ADDRW  = 16,
    parameter int unsigned DATAW  = 64
) (
    input  logic [ADDRW-1:0]        i_addr,
    input  logic                    i_r_w,
    input  logic                    i_busy,
    input  logic                    i_rst_n,
    input  logic [DIM*BITS_C-1:0]   i_c_rd_data,
    output logic                    o_a_wr_en,
    output logic [$clog2(DIM)-1:0]  o_a_wr_row,
    output logic                    o_b_wr_en,
    output logic                    o_c_wr_en,
    output logic                    o_c_wr_hi,
    output logic [$clog2(DIM)-1:0]  o_c_row,
    output logic                    o_start,
    output logic [DATAW-1:0]        o_data_out
);

    logic [MAP_AW-1:0] w_map_addr;
    logic              w_a_hit;
    logic              w_b_hit;
    logic              w_c_hit;
    logic              w_s_hit;
    logic              w_wr_ok;

    assign w_map_addr = i_addr[MAP_AW-1:0];

    assign w_a_hit = in_region(w_map_addr, A_BASE, A_MASK);
    assign w_b_hit = in_region(w_map_addr, B_BASE, B_MASK);
    assign w_c_hit = in_region(w_map_addr, C_BASE, C_MASK);
    assign w_s_hit = (w_map_addr == START_ADDR);

    // Any write is ignored while the array owns the memories or in reset.
    assign w_wr_ok = i_r_w & ~i_busy & i_rst_n;

    assign o_a_wr_en  = w_wr_ok & w_a_hit;
    assign o_b_wr_en  = w_wr_ok & w_b_hit;
    assign o_c_wr_en  = w_wr_ok & w_c_hit;
    assign o_start    = w_wr_ok & w_s_hit;

    assign o_a_wr_row = i_addr[5:3];
    assign o_c_row    = i_addr[6:4];
    assign o_c_wr_hi  = i_addr[3];

    // Reads are not gated by busy: the host may peek at partial results.
    always_comb begin
        o_data_out = '0;
        if (!i_r_w && w_c_hit) begin
            if (i_addr[3]) begin
                o_data_out = i_c_rd_data[DIM*BITS_C-1:DATAW];
            end else begin
                o_data_out = i_c_rd_data[DATAW-1:0];
            end
        end
    end

endmodule

// File: rtl/tpuv1_mmio_ctrl.sv
// tpuv1 host MMIO controller: responds on the host bus, produces A/B/C write
// strobes for memA/memB/systolic_array and runs the fixed-length compute window.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   host            host bus (slave side)
//   busy, done      compute window active / one-cycle completion pulse
//   a_wr_en, a_wr_row, b_wr_en, ab_wr_data   A row write / B row push
//   c_wr_en, c_wr_hi, c_row, c_rd_data        C half-row write and row read
//   mem_en, sa_en   memA/memB shift and array enable during the window
module tpuv1_mmio_ctrl
    import tpuv1_pkg::*;
#(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16,
    parameter int unsigned DIM     = 8,
    parameter int unsigned ADDRW   = 16,
    parameter int unsigned DATAW   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tpuv1_mmio_ctrl_if.slave        host,
    output logic                    busy,
    output logic                    done,
    output logic                    a_wr_en,
    output logic [$clog2(DIM)-1:0]  a_wr_row,
    output logic                    b_wr_en,
    output logic [DATAW-1:0]        ab_wr_data,
    output logic                    c_wr_en,
    output logic                    c_wr_hi,
    output logic [$clog2(DIM)-1:0]  c_row,
    input  logic [DIM*BITS_C-1:0]   c_rd_data,
    output logic                    mem_en,
    output logic                    sa_en
);

    if (DATAW != DIM * BITS_AB) begin : g_bad_ab_width
        $error("DATAW must equal DIM*BITS_AB");
    end
    if (2 * DATAW != DIM * BITS_C) begin : g_bad_c_width
        $error("DATAW must equal DIM*BITS_C/2");
    end

    ctrl_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic              w_start;

    tpuv1_addr_decode #(
        .BITS_C (BITS_C),
        .DIM    (DIM),
        .ADDRW  (ADDRW),
        .DATAW  (DATAW)
    ) u_decode (
        .i_addr      (host.addr),
        .i_r_w       (host.r_w),
        .i_busy      (r_busy),
        .i_rst_n     (rst_n),
        .i_c_rd_data (c_rd_data),
        .o_a_wr_en   (a_wr_en),
        .o_a_wr_row  (a_wr_row),
        .o_b_wr_en   (b_wr_en),
        .o_c_wr_en   (c_wr_en),
        .o_c_wr_hi   (c_wr_hi),
        .o_c_row     (c_row),
        .o_start     (w_start),
        .o_data_out  (host.dataOut)
    );

    assign ab_wr_data = host.dataIn;

    // busy/done are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(RUN_CYC - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    // Back-to-back start is accepted in the completion cycle.
                    r_cnt <= '0;
                    if (w_start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign mem_en = r_busy;
    assign sa_en  = r_busy;

endmodule

// File: tb/tb_tpuv1_mmio_ctrl.sv
// Directed self-checking bench for tpuv1_mmio_ctrl.
module tb_tpuv1_mmio_ctrl;

    logic         clk;
    logic         rst_n;
    logic         busy, done, a_wr_en, b_wr_en, c_wr_en, c_wr_hi, mem_en, sa_en;
    logic [2:0]   a_wr_row, c_row;
    logic [63:0]  ab_wr_data;
    logic [127:0] c_rd_data;

    int checks = 0;
    int errors = 0;

    tpuv1_mmio_ctrl_if #(.ADDRW(16), .DATAW(64)) hif ();

    tpuv1_mmio_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (hif),
        .busy       (busy),
        .done       (done),
        .a_wr_en    (a_wr_en),
        .a_wr_row   (a_wr_row),
        .b_wr_en    (b_wr_en),
        .ab_wr_data (ab_wr_data),
        .c_wr_en    (c_wr_en),
        .c_wr_hi    (c_wr_hi),
        .c_row      (c_row),
        .c_rd_data  (c_rd_data),
        .mem_en     (mem_en),
        .sa_en      (sa_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a start write across edge N, then samples cycles N+1..N+30.
    // With disturb set, writes to A, B, C and start are driven during busy.
    task automatic run_measure(input bit disturb, output int n_busy, output int n_done,
                               output int k_done, output int n_en_bad);
        n_busy = 0; n_done = 0; k_done = -1; n_en_bad = 0;
        hif.addr = 16'h0400;
        hif.r_w  = 1'b1;
        step();
        for (int k = 1; k <= 30; k++) begin
            hif.addr = 16'h0000;
            hif.r_w  = 1'b0;
            if (disturb && k >= 3 && k <= 6) begin
                case (k)
                    3:       hif.addr = 16'h0100;
                    4:       hif.addr = 16'h0200;
                    5:       hif.addr = 16'h0308;
                    default: hif.addr = 16'h0400;
                endcase
                hif.r_w = 1'b1;
                #1;
                chk($sformatf("busy_wr_strobes_k%0d", k),
                    {61'd0, a_wr_en, b_wr_en, c_wr_en}, 64'd0);
            end
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin
                n_done++;
                k_done = k;
            end
            if (sa_en !== busy || mem_en !== busy) n_en_bad++;
            @(posedge clk);
            #1;
        end
        hif.addr = 16'h0000;
        hif.r_w  = 1'b0;
    endtask

    initial begin
        int nb, nd, kd, ne, b_pulses, late_done;
        logic [63:0] exp_d;

        // Reset with a live C read presented.
        rst_n     = 1'b0;
        hif.addr  = 16'h0310;
        hif.r_w   = 1'b0;
        hif.dataIn = 64'd0;
        c_rd_data = {16{8'h5A}};
        step();
        step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_live_read", hif.dataOut, 64'h5A5A5A5A5A5A5A5A);
        chk("rst_c_row", {61'd0, c_row}, 64'd1);

        // A write during reset produces no strobe.
        hif.addr = 16'h0100;
        hif.r_w  = 1'b1;
        #1;
        chk("rst_a_gated", {63'd0, a_wr_en}, 64'd0);

        // Start held during reset does not launch a run.
        hif.addr = 16'h0400;
        step();
        step();
        hif.addr = 16'h0000;
        hif.r_w  = 1'b0;
        rst_n    = 1'b1;
        step();
        chk("rst_start_ignored", {63'd0, busy}, 64'd0);
        step();
        chk("rst_start_ignored2", {63'd0, busy}, 64'd0);

        // A row writes.
        for (int r = 0; r < 8; r++) begin
            hif.addr   = 16'h0100 + 16'(8 * r);
            hif.r_w    = 1'b1;
            exp_d      = 64'h0101010101010101 * 64'(r);
            hif.dataIn = exp_d;
            #1;
            chk($sformatf("a_wr_en_r%0d", r), {63'd0, a_wr_en}, 64'd1);
            chk($sformatf("a_wr_row_r%0d", r), {61'd0, a_wr_row}, 64'(r));
            chk($sformatf("ab_wr_data_r%0d", r), ab_wr_data, exp_d);
            chk($sformatf("a_no_b_c_r%0d", r), {62'd0, b_wr_en, c_wr_en}, 64'd0);
            step();
        end

        // Three B pushes.
        b_pulses = 0;
        hif.addr = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (b_wr_en === 1'b1) b_pulses++;
            step();
        end
        hif.r_w = 1'b0;
        #1;
        chk("b_pulses", 64'(b_pulses), 64'd3);
        chk("b_read_no_strobe", {63'd0, b_wr_en}, 64'd0);

        // C high-half write strobe.
        hif.addr = 16'h0338;
        hif.r_w  = 1'b1;
        #1;
        chk("c_wr_en", {63'd0, c_wr_en}, 64'd1);
        chk("c_wr_hi", {63'd0, c_wr_hi}, 64'd1);
        chk("c_wr_row", {61'd0, c_row}, 64'd3);
        chk("c_wr_dataout_zero", hif.dataOut, 64'd0);
        step();

        // C reads, zero-latency.
        c_rd_data = {64'hAAAAAAAAAAAAAAAA, 64'h1111111111111111};
        hif.r_w   = 1'b0;
        hif.addr  = 16'h0338;
        #1;
        chk("c_rd_row", {61'd0, c_row}, 64'd3);
        chk("c_rd_hi", hif.dataOut, 64'hAAAAAAAAAAAAAAAA);
        hif.addr = 16'h0330;
        #1;
        chk("c_rd_lo", hif.dataOut, 64'h1111111111111111);
        hif.addr = 16'h0500;
        #1;
        chk("rd_unmapped", hif.dataOut, 64'd0);
        hif.addr = 16'h0000;
        step();

        // Plain run.
        run_measure(1'b0, nb, nd, kd, ne);
        chk("run_busy_len", 64'(nb), 64'd23);
        chk("run_done_cnt", 64'(nd), 64'd1);
        chk("run_done_at", 64'(kd), 64'd24);
        chk("run_en_follow", 64'(ne), 64'd0);
        chk("run_busy_after", {63'd0, busy}, 64'd0);

        // Run with writes attempted while busy.
        run_measure(1'b1, nb, nd, kd, ne);
        chk("dist_busy_len", 64'(nb), 64'd23);
        chk("dist_done_cnt", 64'(nd), 64'd1);
        chk("dist_done_at", 64'(kd), 64'd24);

        // Reset mid-run aborts without a done pulse.
        hif.addr = 16'h0400;
        hif.r_w  = 1'b1;
        step();
        hif.addr = 16'h0000;
        hif.r_w  = 1'b0;
        for (int k = 1; k < 10; k++) step();
        step();
        rst_n = 1'b0;
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        step();
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        step();
        rst_n = 1'b1;
        late_done = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1 || busy === 1'b1) late_done++;
            step();
        end
        chk("abort_no_done", 64'(late_done), 64'd0);

        run_measure(1'b0, nb, nd, kd, ne);
        chk("rerun_busy_len", 64'(nb), 64'd23);
        chk("rerun_done_at", 64'(kd), 64'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
